// File: rtl/agdc_pkg.sv
// -----------------------------------------------------------------------------
// agdc_pkg
// Shared definitions for the garage-door input conditioner:
//   - press FSM state encoding (localparams plus an enum built on them)
//   - default debounce / lockout lengths
//   - counter width helper (never narrower than 1 bit)
// -----------------------------------------------------------------------------
package agdc_pkg;

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] PULSE    = 2'b01;
    localparam logic [1:0] LOCK     = 2'b10;
    localparam logic [1:0] WAIT_REL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = IDLE,
        S_PULSE    = PULSE,
        S_LOCK     = LOCK,
        S_WAIT_REL = WAIT_REL
    } press_state_e;

    localparam int DB_CYCLES_DEF      = 16;
    localparam int LOCKOUT_CYCLES_DEF = 64;

    // Width of a counter that must hold 0 .. n-1; $clog2(1) is 0, so clamp to 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/agdc_debounce.sv
// -----------------------------------------------------------------------------
// agdc_debounce
// Two-flop synchroniser followed by a stability counter. The debounced level
// only changes after DB_CYCLES consecutive synchronised samples disagree with
// it; a single agreeing sample clears the count, so any glitch restarts
// qualification.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-low reset
//   din_raw  in   asynchronous raw input
//   dout     out  debounced level (register output)
// -----------------------------------------------------------------------------
module agdc_debounce
    import agdc_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic din_raw,
    output logic dout
);

    localparam int             CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q,    db_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = din_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/agdc_input_cond.sv
// -----------------------------------------------------------------------------
// agdc_input_cond
// Input conditioner in front of the garage door FSM. Debounces the wall
// button and both limit switches, turns each accepted press into a single
// Activate pulse followed by a lockout window, and flags both limits closed.
//
// State table (press FSM):
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | waiting for a debounced press
//   PULSE     | Activate high for this one cycle, lockout counter loaded
//   LOCK      | lockout running, presses ignored (not queued)
//   WAIT_REL  | press consumed or swallowed by a fault; wait for release
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST          in   asynchronous active-low reset
//   BTN_raw      in   raw wall button / remote, active high, bouncy
//   UP_SW_raw    in   raw up-limit switch, active high
//   DN_SW_raw    in   raw down-limit switch, active high
//   Activate     out  one-cycle pulse per accepted press
//   UP_Max       out  debounced up-limit
//   DN_Max       out  debounced down-limit
//   Limit_Fault  out  both limits closed
//   Busy         out  press FSM not in IDLE
// -----------------------------------------------------------------------------
module agdc_input_cond
    import agdc_pkg::*;
#(
    parameter int DB_CYCLES      = DB_CYCLES_DEF,
    parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_raw,
    input  logic UP_SW_raw,
    input  logic DN_SW_raw,
    output logic Activate,
    output logic UP_Max,
    output logic DN_Max,
    output logic Limit_Fault,
    output logic Busy
);

    localparam int            LW        = cnt_width(LOCKOUT_CYCLES);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

    logic btn_db;
    logic up_db;
    logic dn_db;
    logic fault;

    agdc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_btn (
        .CLK     (CLK),
        .RST     (RST),
        .din_raw (BTN_raw),
        .dout    (btn_db)
    );

    agdc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .CLK     (CLK),
        .RST     (RST),
        .din_raw (UP_SW_raw),
        .dout    (up_db)
    );

    agdc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .CLK     (CLK),
        .RST     (RST),
        .din_raw (DN_SW_raw),
        .dout    (dn_db)
    );

    assign fault = up_db & dn_db;

    press_state_e  state_q,    state_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          activate_q, activate_d;
    logic          busy_q,     busy_d;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            S_IDLE: begin
                // A press coinciding with a fault is swallowed, not deferred.
                if (btn_db) begin
                    state_d = fault ? S_WAIT_REL : S_PULSE;
                end
            end
            S_PULSE: begin
                state_d    = S_LOCK;
                lock_cnt_d = LOCK_LOAD;
            end
            S_LOCK: begin
                if (lock_cnt_q == '0) begin
                    state_d = btn_db ? S_WAIT_REL : S_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
            end
            S_WAIT_REL: begin
                if (!btn_db) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state, so they line up exactly
        // with state_q and carry no decode glitches.
        activate_d = (state_d == S_PULSE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            lock_cnt_q <= '0;
            activate_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            activate_q <= activate_d;
            busy_q     <= busy_d;
        end
    end

    assign Activate    = activate_q;
    assign Busy        = busy_q;
    assign UP_Max      = up_db;
    assign DN_Max      = dn_db;
    assign Limit_Fault = fault;

endmodule

// File: tb/tb_agdc_input_cond.sv
// -----------------------------------------------------------------------------
// tb_agdc_input_cond
// Self-checking bench for agdc_input_cond with DB_CYCLES=4, LOCKOUT_CYCLES=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Each test pushes the cycle number at which an Activate pulse is expected;
// the monitor pops and compares whenever the DUT raises Activate.
// With inputs changed after falling edge N, the debounced level moves at
// rising edge N+6 and a resulting pulse is seen at cycle N+7.
// -----------------------------------------------------------------------------
module tb_agdc_input_cond;

    localparam int DB = 4;
    localparam int LK = 8;

    logic CLK       = 1'b0;
    logic RST       = 1'b0;
    logic BTN_raw   = 1'b1;
    logic UP_SW_raw = 1'b1;
    logic DN_SW_raw = 1'b1;
    logic Activate;
    logic UP_Max;
    logic DN_Max;
    logic Limit_Fault;
    logic Busy;

    int cyc        = 0;
    int compared   = 0;
    int mismatched = 0;
    int exp_q[$];
    int exp_cyc;

    agdc_input_cond #(
        .DB_CYCLES      (DB),
        .LOCKOUT_CYCLES (LK)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BTN_raw     (BTN_raw),
        .UP_SW_raw   (UP_SW_raw),
        .DN_SW_raw   (DN_SW_raw),
        .Activate    (Activate),
        .UP_Max      (UP_Max),
        .DN_Max      (DN_Max),
        .Limit_Fault (Limit_Fault),
        .Busy        (Busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard consumer: every observed pulse must match the oldest expected one.
    always @(negedge CLK) begin
        if (Activate !== 1'b0) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL activate_unexpected: pulse (%b) at cycle %0d, required none", Activate, cyc);
            end else begin
                exp_cyc = exp_q.pop_front();
                if (cyc !== exp_cyc) begin
                    mismatched++;
                    $display("FAIL activate_timing: pulse at cycle %0d, required cycle %0d", cyc, exp_cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: still running at cycle %0d, required completion", cyc);
        $fatal(1);
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    task automatic test_reset;
        int n;
        RST = 1'b0;
        BTN_raw = 1'b1; UP_SW_raw = 1'b1; DN_SW_raw = 1'b1;
        repeat (4) @(negedge CLK);
        compared++;
        if ({Activate, Busy, UP_Max, DN_Max, Limit_Fault} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {Activate, Busy, UP_Max, DN_Max, Limit_Fault});
        end
        n = cyc;
        RST = 1'b1;
        BTN_raw = 1'b0; UP_SW_raw = 1'b1; DN_SW_raw = 1'b0;
        wait_until(n + 5);
        compared++;
        if (UP_Max !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_up_early: UP_Max %b at edge 5, required 0", UP_Max);
        end
        wait_until(n + 6);
        compared++;
        if ({UP_Max, DN_Max, Limit_Fault} !== 3'b100) begin
            mismatched++;
            $display("FAIL reset_up_rise: {UP,DN,FLT} %b at edge 6, required 100", {UP_Max, DN_Max, Limit_Fault});
        end
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 5; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                BTN_raw = (ph == 0);
                repeat (2) begin
                    @(negedge CLK);
                    compared++;
                    if ({Activate, Busy} !== 2'b00) begin
                        mismatched++;
                        $display("FAIL bounce_quiet: {Activate,Busy} %b at cycle %0d, required 00", {Activate, Busy}, cyc);
                    end
                end
            end
        end
        BTN_raw = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            compared++;
            if (Busy !== 1'b0) begin
                mismatched++;
                $display("FAIL bounce_settle: Busy %b at cycle %0d, required 0", Busy, cyc);
            end
        end
    endtask

    task automatic test_clean_press;
        int n;
        logic exp_busy;
        UP_SW_raw = 1'b0; DN_SW_raw = 1'b1;
        repeat (10) @(negedge CLK);
        compared++;
        if ({UP_Max, DN_Max, Limit_Fault} !== 3'b010) begin
            mismatched++;
            $display("FAIL clean_limits: {UP,DN,FLT} %b, required 010", {UP_Max, DN_Max, Limit_Fault});
        end
        n = cyc;
        BTN_raw = 1'b1;
        exp_q.push_back(n + 7);
        for (int k = 1; k <= 40; k++) begin
            wait_until(n + k);
            exp_busy = (k >= 7 && k <= 36);
            compared++;
            if (Busy !== exp_busy) begin
                mismatched++;
                $display("FAIL clean_busy: Busy %b at press+%0d, required %b", Busy, k, exp_busy);
            end
            if (k == 30) BTN_raw = 1'b0;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL clean_missing_pulse: %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int m;
        n = cyc;
        BTN_raw = 1'b1;
        exp_q.push_back(n + 7);
        wait_until(n + 12);
        BTN_raw = 1'b0;
        wait_until(n + 14);
        BTN_raw = 1'b1;
        wait_until(n + 20);
        compared++;
        if (Busy !== 1'b1) begin
            mismatched++;
            $display("FAIL relock_wait_rel: Busy %b after lockout with re-press held, required 1", Busy);
        end
        wait_until(n + 30);
        BTN_raw = 1'b0;
        wait_until(n + 36);
        compared++;
        if (Busy !== 1'b1) begin
            mismatched++;
            $display("FAIL relock_busy_hold: Busy %b before debounced release, required 1", Busy);
        end
        wait_until(n + 37);
        compared++;
        if (Busy !== 1'b0) begin
            mismatched++;
            $display("FAIL relock_busy_fall: Busy %b after debounced release, required 0", Busy);
        end
        repeat (3) @(negedge CLK);
        m = cyc;
        BTN_raw = 1'b1;
        exp_q.push_back(m + 7);
        wait_until(m + 8);
        BTN_raw = 1'b0;
        wait_until(m + 15);
        compared++;
        if (Busy !== 1'b1) begin
            mismatched++;
            $display("FAIL second_busy_lock: Busy %b in last lockout cycle, required 1", Busy);
        end
        wait_until(m + 16);
        compared++;
        if (Busy !== 1'b0) begin
            mismatched++;
            $display("FAIL second_busy_end: Busy %b after lockout, required 0", Busy);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL relock_missing_pulse: %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_fault;
        int n;
        int p;
        int q;
        n = cyc;
        UP_SW_raw = 1'b1;
        wait_until(n + 5);
        compared++;
        if (Limit_Fault !== 1'b0) begin
            mismatched++;
            $display("FAIL fault_early: Limit_Fault %b at edge 5, required 0", Limit_Fault);
        end
        wait_until(n + 6);
        compared++;
        if (Limit_Fault !== 1'b1) begin
            mismatched++;
            $display("FAIL fault_rise: Limit_Fault %b at edge 6, required 1", Limit_Fault);
        end
        p = cyc;
        BTN_raw = 1'b1;
        wait_until(p + 6);
        compared++;
        if (Busy !== 1'b0) begin
            mismatched++;
            $display("FAIL fault_busy_pre: Busy %b at press+6, required 0", Busy);
        end
        wait_until(p + 7);
        compared++;
        if (Busy !== 1'b1) begin
            mismatched++;
            $display("FAIL fault_swallow: Busy %b at press+7, required 1 (press swallowed)", Busy);
        end
        wait_until(p + 10);
        UP_SW_raw = 1'b0;
        wait_until(p + 16);
        compared++;
        if ({Limit_Fault, Busy} !== 2'b01) begin
            mismatched++;
            $display("FAIL fault_clear_held: {FLT,Busy} %b, required 01", {Limit_Fault, Busy});
        end
        wait_until(p + 25);
        BTN_raw = 1'b0;
        wait_until(p + 31);
        compared++;
        if (Busy !== 1'b1) begin
            mismatched++;
            $display("FAIL fault_busy_hold: Busy %b before release, required 1", Busy);
        end
        wait_until(p + 32);
        compared++;
        if (Busy !== 1'b0) begin
            mismatched++;
            $display("FAIL fault_busy_fall: Busy %b after release, required 0", Busy);
        end
        repeat (2) @(negedge CLK);
        q = cyc;
        BTN_raw = 1'b1;
        exp_q.push_back(q + 7);
        wait_until(q + 8);
        BTN_raw = 1'b0;
        wait_until(q + 16);
        compared++;
        if (Busy !== 1'b0) begin
            mismatched++;
            $display("FAIL fault_fresh_idle: Busy %b after fresh press lockout, required 0", Busy);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL fault_missing_pulse: %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_lock;
        int n;
        int r;
        n = cyc;
        BTN_raw = 1'b1;
        exp_q.push_back(n + 7);
        wait_until(n + 10);
        compared++;
        if (Busy !== 1'b1) begin
            mismatched++;
            $display("FAIL midlock_busy: Busy %b in lockout, required 1", Busy);
        end
        RST = 1'b0;
        #1;
        compared++;
        if ({Activate, Busy, UP_Max, DN_Max, Limit_Fault} !== 5'b0) begin
            mismatched++;
            $display("FAIL midlock_async_clear: outputs %b, required 00000",
                     {Activate, Busy, UP_Max, DN_Max, Limit_Fault});
        end
        repeat (3) @(negedge CLK);
        r = cyc;
        RST = 1'b1;
        exp_q.push_back(r + 7);
        wait_until(r + 6);
        compared++;
        if ({Busy, DN_Max} !== 2'b01) begin
            mismatched++;
            $display("FAIL midlock_rearm: {Busy,DN_Max} %b at edge 6, required 01", {Busy, DN_Max});
        end
        wait_until(r + 8);
        BTN_raw = 1'b0;
        wait_until(r + 16);
        compared++;
        if (Busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midlock_idle: Busy %b after lockout, required 0", Busy);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL midlock_missing_pulse: %0d pulses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_back_to_back();
        test_fault();
        test_reset_mid_lock();
        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/agdc_input_cond.md
# agdc_input_cond

Input conditioner for the automatic garage door controller. It sits directly upstream of the door FSM. It synchronises and debounces the raw wall-button and the two limit switches, and drives the FSM's `Activate`, `UP_Max` and `DN_Max` inputs. Each qualified button press becomes exactly one single-cycle `Activate` pulse, followed by a lockout window. The block also flags the physically impossible case of both limits closed.

## Interface
Parameters:
- `DB_CYCLES`, default 16: consecutive stable synchronised samples needed to accept a level change; ≥1.
- `LOCKOUT_CYCLES`, default 64: cycles after a pulse during which presses are ignored; ≥1.

Counter widths are derived internally with `$clog2`, minimum 1 bit.

Ports:
- `CLK`  in  1: single system clock, rising-edge.
- `RST`  in  1: asynchronous, active-low reset.
- `BTN_raw`  in  1: wall button or remote, active-high, asynchronous and bouncy.
- `UP_SW_raw`  in  1: up-limit switch, active-high, asynchronous.
- `DN_SW_raw`  in  1: down-limit switch, active-high, asynchronous.
- `Activate`  out  1: one-cycle pulse per accepted press.
- `UP_Max`  out  1: debounced up-limit level.
- `DN_Max`  out  1: debounced down-limit level.
- `Limit_Fault`  out  1: `UP_Max & DN_Max`.
- `Busy`  out  1: high whenever the press FSM is not in IDLE.

## Operation
Per-channel conditioning (identical for all three inputs):
- Two-flop synchroniser, then debounce register `db` and counter `cnt`.
- Each edge where `sync != db`:
  - if `cnt == DB_CYCLES-1`: `db <= sync`, `cnt <= 0`;
  - else `cnt <= cnt+1`.
- Each edge where `sync == db`: `cnt <= 0`. Any glitch therefore restarts qualification.

Press FSM, four states:
- IDLE: if debounced button is 1 and `Limit_Fault` is 0, go to PULSE. If debounced button is 1 and `Limit_Fault` is 1, go to WAIT_REL (press swallowed). Otherwise stay.
- PULSE: `Activate=1`. Go to LOCK and load the lockout counter with `LOCKOUT_CYCLES-1`.
- LOCK: decrement each cycle. At 0, go to WAIT_REL if the debounced button is still 1, else go to IDLE. Presses during LOCK are ignored, not queued.
- WAIT_REL: stay until the debounced button is 0, then go to IDLE. This guarantees one pulse per press, including a press held across a fault clearing.

Outputs:
- `Activate` and `Busy` are decoded from the registered state only (Moore, glitch-free).
- `UP_Max` and `DN_Max` are the `db` registers directly.
- `Limit_Fault` is a combinational AND of two registers.

Reset:
- `RST` low asynchronously clears all synchronisers, `db`, `cnt` and the lockout counter, and forces IDLE.
- All outputs read 0 during and after reset: `Activate`, `Busy`, `UP_Max`, `DN_Max`, `Limit_Fault`.
- Reset mid-LOCK or mid-PULSE aborts immediately with no pulse. A button held through reset release is treated as a new press once debounced.

## Timing
- Counting the first edge that samples a new raw level as edge 1, `db` takes the new value at edge `DB_CYCLES+2`, provided the input is stable throughout.
- Debounced button rises at edge E. The FSM enters PULSE at E+1. `Activate` is high for exactly the cycle between E+1 and E+2, and LOCK is entered at E+2.
- `Busy` stays high for 1 (PULSE) + `LOCKOUT_CYCLES` (LOCK) cycles, plus any WAIT_REL time.
- Minimum spacing between two `Activate` pulses is `LOCKOUT_CYCLES+2` cycles plus the release and re-debounce time.
- Simultaneous fault and press in IDLE: the fault wins and no pulse is issued.
- A fault arising during LOCK or WAIT_REL has no effect on an already-issued pulse.

## Structure
- Shared package `agdc_pkg` holds:
  - state encoding localparams: IDLE `2'b00`, PULSE `2'b01`, LOCK `2'b10`, WAIT_REL `2'b11`;
  - default `DB_CYCLES` and `LOCKOUT_CYCLES` values.
- Sub-module `agdc_debounce` (param `DB_CYCLES`; ports `CLK`, `RST`, `din_raw`, `dout`) contains the synchroniser and counter. It is instantiated three times.
- Top level holds the press FSM, the lockout counter and the fault logic.

## Test plan
All scenarios use `DB_CYCLES=4` and `LOCKOUT_CYCLES=8`.
- Reset: `RST` low with all raw inputs at 1 → every output is 0. After release, `UP_SW_raw=1` and `DN_SW_raw=0` → `UP_Max` rises at edge 6 and `DN_Max` stays 0.
- Bounce: `BTN_raw` toggles every 2 cycles for 20 cycles, then held 0 → debounced button never rises, `Activate` stays 0, `Busy` stays 0.
- Clean press: `BTN_raw` high for 30 cycles with `DN_SW_raw=1` → exactly one `Activate` pulse, in the cycle after the debounced rise. `Busy` is high for 9 cycles, then remains high in WAIT_REL until the debounced release.
- Re-press in lockout: press 6 cycles after debounce, release, re-press 2 cycles later → no second pulse. A press issued after `Busy` falls → second pulse.
- Fault: both limit raws at 1 → `Limit_Fault` at edge 6. A press then gives no `Activate` and `Busy` high (WAIT_REL). Clearing the fault while the button is held → still no pulse until release and a fresh press.
- Reset mid-LOCK: assert `RST` 3 cycles into LOCK → `Busy` and `Activate` go 0 asynchronously and the FSM returns to IDLE. After release, the held button produces one new pulse after debounce.
